// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions: skid-buffer state encoding and occupancy decode.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] state_occupancy(input skid_state_e s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register with flush and back-pressure statistics.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned PAYLOAD_W     = 32,
    parameter int unsigned CLEAR_PAYLOAD = 1,
    parameter int unsigned STALL_CNT_W   = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [PAYLOAD_W-1:0]   InData,
    input  logic                   Flush,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [PAYLOAD_W-1:0]   OutData,
    output logic [1:0]             Occupancy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    skid_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 accept;
    logic                 pop;
    logic                 stall_inc;

    // Handshake flags come from registered state only, so InReady never depends on OutReady.
    assign OutValid  = (state_q != EMPTY);
    assign InReady   = (state_q != FULL);
    assign OutData   = main_q;
    assign Occupancy = state_occupancy(state_q);

    assign accept    = InValid && InReady;
    assign pop       = OutValid && OutReady;
    assign stall_inc = OutValid && !OutReady && !Flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = InData;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_d = InData;
                end else if (accept) begin
                    skid_d  = InData;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only invalidates; payload registers keep their contents.
        if (Flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (CLEAR_PAYLOAD != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .Clk  (Clk),
        .Reset(Reset),
        .Inc  (stall_inc),
        .Count(StallCount)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: per-scenario tasks plus an in-order output scoreboard.
module tb_pipe_stage_skid;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] InData = '0;
    logic        Flush = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutData;
    logic [1:0]  Occupancy;
    logic [3:0]  StallCount;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] sb[$];

    pipe_stage_skid #(
        .PAYLOAD_W    (32),
        .CLEAR_PAYLOAD(1),
        .STALL_CNT_W  (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .Flush     (Flush),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .Occupancy (Occupancy),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: record accepted payloads, compare every pop against the oldest one.
    always @(negedge Clk) begin
        if (Reset) begin
            sb.delete();
        end else begin
            if (OutValid && OutReady) begin
                pops++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: got %h, expected nothing queued", OutData);
                end else begin
                    logic [31:0] exp;
                    exp = sb.pop_front();
                    if (OutData !== exp) begin
                        errors++;
                        $display("FAIL sb_pop: got %h, expected %h", OutData, exp);
                    end
                end
            end
            if (Flush) begin
                sb.delete();
            end else if (InValid && InReady) begin
                sb.push_back(InData);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b, expected 0", OutValid); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b, expected 1", InReady); end
        checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d, expected 0", Occupancy); end
        checks++; if (StallCount !== 4'h0) begin errors++; $display("FAIL reset_stall: got %h, expected 0", StallCount); end
        checks++; if (OutData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, expected 0", OutData); end
    endtask

    task automatic test_single();
        do_reset();
        InValid = 1'b1; InData = 32'hA5A5_0001; OutReady = 1'b1;
        tick();
        InValid = 1'b0; InData = 32'hFFFF_FFFF;
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", OutValid); end
        checks++; if (OutData !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h, expected a5a50001", OutData); end
        checks++; if (Occupancy !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d, expected 1", Occupancy); end
        tick();
        checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL single_drain: got %0d, expected 0", Occupancy); end
    endtask

    task automatic test_ignore();
        // EMPTY with OutReady high and junk data but no InValid: nothing changes.
        OutReady = 1'b1; InValid = 1'b0; InData = 32'h1234_5678;
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL ignore_valid: got %b, expected 0", OutValid); end
        checks++; if (OutData !== 32'hA5A5_0001) begin errors++; $display("FAIL ignore_data: got %h, expected a5a50001", OutData); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        OutReady = 1'b0;
        InValid = 1'b1; InData = 32'h1; tick();
        InData = 32'h2; tick();
        InValid = 1'b0;
        checks++; if (Occupancy !== 2'd2) begin errors++; $display("FAIL fill_occ: got %0d, expected 2", Occupancy); end
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL fill_inready: got %b, expected 0", InReady); end
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL fill_stall: got %0d, expected 1", StallCount); end
        checks++; if (OutData !== 32'h1) begin errors++; $display("FAIL drain_first: got %h, expected 1", OutData); end
        OutReady = 1'b1;
        tick();
        checks++; if (OutData !== 32'h2 || Occupancy !== 2'd1) begin errors++; $display("FAIL drain_second: got %h occ %0d, expected 2 occ 1", OutData, Occupancy); end
        tick();
        checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL drain_empty: got %0d, expected 0", Occupancy); end
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL drain_stall: got %0d, expected 1", StallCount); end
    endtask

    task automatic test_flush();
        do_reset();
        OutReady = 1'b0;
        InValid = 1'b1; InData = 32'h10; tick();
        InData = 32'h11; tick();
        Flush = 1'b1; InData = 32'hDEAD_BEEF;
        tick();
        Flush = 1'b0; InValid = 1'b0;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, expected 0", OutValid); end
        checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d, expected 0", Occupancy); end
        checks++; if (OutData !== 32'h10) begin errors++; $display("FAIL flush_payload_kept: got %h, expected 10", OutData); end
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL flush_stall: got %0d, expected 1", StallCount); end
        OutReady = 1'b1; InValid = 1'b1; InData = 32'h12;
        tick();
        InValid = 1'b0;
        checks++; if (OutData !== 32'h12) begin errors++; $display("FAIL flush_next: got %h, expected 12", OutData); end
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL flush_sb_left: got %0d entries, expected 0", sb.size()); end
    endtask

    task automatic test_saturate();
        do_reset();
        OutReady = 1'b0;
        InValid = 1'b1; InData = 32'h20; tick();
        InValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 4) begin
                checks++; if (StallCount !== 4'd5) begin errors++; $display("FAIL sat_mid: got %0d, expected 5", StallCount); end
            end
        end
        checks++; if (StallCount !== 4'hF) begin errors++; $display("FAIL sat_top: got %h, expected f", StallCount); end
        tick(); tick(); tick();
        checks++; if (StallCount !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h, expected f", StallCount); end
        OutReady = 1'b1;
        tick();
        checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL sat_drain: got %0d, expected 0", Occupancy); end
    endtask

    task automatic test_reset_full();
        do_reset();
        OutReady = 1'b0;
        InValid = 1'b1; InData = 32'h30; tick();
        InData = 32'h31; tick();
        Reset = 1'b1; Flush = 1'b1; InData = 32'h99;
        tick();
        Reset = 1'b0; Flush = 1'b0; InValid = 1'b0;
        checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL rstfull_hs: got v%b r%b, expected v0 r1", OutValid, InReady); end
        checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL rstfull_occ: got %0d, expected 0", Occupancy); end
        checks++; if (StallCount !== 4'd0) begin errors++; $display("FAIL rstfull_stall: got %0d, expected 0", StallCount); end
        checks++; if (OutData !== 32'h0) begin errors++; $display("FAIL rstfull_data: got %h, expected 0", OutData); end
    endtask

    task automatic test_back_to_back();
        int start_pops;
        do_reset();
        start_pops = pops;
        OutReady = 1'b1; InValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            InData = 32'(i);
            tick();
            checks++;
            if (Occupancy !== 2'd1 || OutData !== 32'(i)) begin
                errors++;
                $display("FAIL stream_%0d: got occ %0d data %h, expected occ 1 data %h", i, Occupancy, OutData, 32'(i));
            end
        end
        InValid = 1'b0;
        tick();
        checks++; if (pops - start_pops != 100) begin errors++; $display("FAIL stream_count: got %0d pops, expected 100", pops - start_pops); end
        checks++; if (sb.size() != 0 || Occupancy !== 2'd0) begin errors++; $display("FAIL stream_end: got %0d queued occ %0d, expected 0 and 0", sb.size(), Occupancy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignore();
        test_fill_drain();
        test_flush();
        test_saturate();
        test_reset_full();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 32, bit width of the stage payload (control plus data fields, concatenated).
REQ-002 SHALL have parameter CLEAR_PAYLOAD, default 1, where 1 zeroes the payload registers on Reset and 0 leaves them unchanged.
REQ-003 SHALL have parameter STALL_CNT_W, default 16, bit width of the stall counter.
REQ-004 SHALL have port Clk, input, 1 bit: clock; all state updates on posedge.
REQ-005 SHALL have port Reset, input, 1 bit: reset; synchronous, active-high.
REQ-006 SHALL have port InValid, input, 1 bit: upstream stage presents a valid payload.
REQ-007 SHALL have port InReady, output, 1 bit: stage accepts a payload this cycle.
REQ-008 SHALL have port InData, input, PAYLOAD_W bits: upstream payload.
REQ-009 SHALL have port Flush, input, 1 bit: discard all held payloads (branch or hazard squash).
REQ-010 SHALL have port OutValid, output, 1 bit: OutData is valid.
REQ-011 SHALL have port OutReady, input, 1 bit: downstream consumes OutData this cycle.
REQ-012 SHALL have port OutData, output, PAYLOAD_W bits: oldest held payload.
REQ-013 SHALL have port Occupancy, output, 2 bits: number of held payloads (0, 1 or 2).
REQ-014 SHALL have port StallCount, output, STALL_CNT_W bits: saturating count of back-pressure cycles.

Function
REQ-015 SHALL accept a payload in a cycle exactly when InValid && InReady.
REQ-016 SHALL consume (pop) a payload in a cycle exactly when OutValid && OutReady.
REQ-017 SHALL implement a 2-entry skid buffer: main register (drives OutData) plus skid register.
REQ-018 SHALL use FSM states EMPTY, ONE and FULL, and SHALL drive Occupancy as 0, 1 and 2 respectively.
REQ-019 SHALL drive OutValid = (state != EMPTY) and InReady = (state != FULL), both decoded from registered state only, with no combinational path from OutReady to InReady.
REQ-020 SHALL, in EMPTY with an accept, load main and move to ONE; OutValid SHALL rise the next cycle (1-cycle latency).
REQ-021 SHALL, in ONE with an accept and a pop, load main with InData and stay in ONE.
REQ-022 SHALL, in ONE with an accept and no pop, load skid and move to FULL.
REQ-023 SHALL, in ONE with a pop and no accept, move to EMPTY.
REQ-024 SHALL, in FULL with a pop, copy skid to main and move to ONE; no accept is possible in FULL because InReady = 0.
REQ-025 SHALL deliver payloads in strict arrival order, with no loss and no duplication.
REQ-026 SHALL ignore OutReady in EMPTY and ignore InData when InValid = 0.
REQ-027 SHALL, on Flush = 1, move to EMPTY next cycle regardless of state, accept or pop; the accept in the same cycle SHALL be discarded.
REQ-028 SHALL NOT alter payload registers on Flush; only the valid state is cleared.
REQ-029 SHALL increment StallCount in each cycle with OutValid && !OutReady && !Flush, and SHALL saturate at all-ones with no wrap.
REQ-030 SHALL NOT clear StallCount on Flush.

Reset
REQ-031 SHALL give Reset priority over Flush, InValid and OutReady.
REQ-032 SHALL, on Reset, set state to EMPTY (OutValid = 0, InReady = 1, Occupancy = 0) and StallCount = 0.
REQ-033 SHALL, on Reset, clear main and skid to 0 when CLEAR_PAYLOAD = 1, else leave them unchanged.
REQ-034 SHALL, on Reset mid-operation (ONE or FULL), drop all held payloads and reach EMPTY the following cycle.

Structure
REQ-035 SHALL declare the state encoding (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2) in the shared pipeline package, for reuse by the IF/ID, ID/EX, EX/MEM and MEM/WB instances.
REQ-036 SHALL implement the saturating counter as a sub-module, sat_counter (parameter W; ports Clk, Reset, Inc, Count).
REQ-037 SHALL be instantiable per pipeline stage, with the payload formed by field concatenation at the instantiation site.

Verification
REQ-038 SHALL be verified with: Reset, then InValid = 1, InData = 32'hA5A5_0001, OutReady = 1 -> OutValid = 1, OutData = 32'hA5A5_0001 next cycle, Occupancy = 1.
REQ-039 SHALL be verified with: OutReady = 0, push 32'h1 then 32'h2 -> Occupancy = 2, InReady = 0; then OutReady = 1 -> outputs 32'h1, then 32'h2 on consecutive cycles, then Occupancy = 0.
REQ-040 SHALL be verified with: FULL plus Flush = 1 together with InValid = 1 -> next cycle OutValid = 0, Occupancy = 0, and the flushed data never appears.
REQ-041 SHALL be verified with: STALL_CNT_W = 4, OutValid = 1, OutReady = 0 for 20 cycles -> StallCount = 4'hF and holds there.
REQ-042 SHALL be verified with: Reset asserted in FULL together with Flush = 1 -> EMPTY, StallCount = 0, and payloads = 0 when CLEAR_PAYLOAD = 1.
REQ-043 SHALL be verified with: continuous InValid = 1, OutReady = 1 streaming 32'h0 to 32'h63 (100 payloads) -> one output per cycle, in order, Occupancy held at 1.
